seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 15 +
 rtl/seq_divider_if.sv | 24 ++
 rtl/adder.sv | 12 +
 rtl/seq_divider.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM encoding and counter sizing for seq_divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold the value N itself
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between a requester and seq_divider
interface seq_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Quot;
    logic [N-1:0] Rem;
    logic         busy;
    logic         done;
    logic         FlagZ;
    logic         FlagV;

    modport master (
        output start, A, B,
        input  Quot, Rem, busy, done, FlagZ, FlagV
    );

    modport slave (
        input  start, A, B,
        output Quot, Rem, busy, done, FlagZ, FlagV
    );
endinterface

// File: rtl/adder.sv
// rtl/adder.sv - ripple-style W-bit adder with carry in and carry out
module adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         Cin,
    output logic [W-1:0] sum,
    output logic         FlagC
);
    assign {FlagC, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, Cin};
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring shift-subtract divider, signed mode via SEQ_DIVIDER_SIGNED_EN
module seq_divider
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    localparam int             CW       = cnt_width(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N);

    state_t        state;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N:0]    rem_p;
    logic [N-1:0]  q_reg;
    logic [CW-1:0] cnt;
    logic          neg_q;
    logic          neg_r;
    logic          ovf;

    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic          neg_q_in;
    logic          neg_r_in;
    logic          ovf_in;
    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          no_borrow;
    logic [N-1:0]  q_fin;
    logic [N-1:0]  r_fin;

    // Partial remainder stays below the divisor between iterations, so its MSB is
    // always zero after a step; only the shift/subtract path needs the extra bit.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_p[N];

    // Operand conditioning at capture: magnitudes and result sign fix-ups
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        a_mag    = bus.A[N-1] ? -bus.A : bus.A;
        b_mag    = bus.B[N-1] ? -bus.B : bus.B;
        neg_q_in = bus.A[N-1] ^ bus.B[N-1];
        neg_r_in = bus.A[N-1];
        ovf_in   = (bus.A == {1'b1, {(N-1){1'b0}}}) && (bus.B == '1);
`else
        a_mag    = bus.A;
        b_mag    = bus.B;
        neg_q_in = 1'b0;
        neg_r_in = 1'b0;
        ovf_in   = 1'b0;
`endif
    end

    assign shifted = {rem_p[N-1:0], a_reg[N-1]};

    adder #(.W(N + 1)) u_sub (
        .x     (shifted),
        .y     (~{1'b0, b_reg}),
        .Cin   (1'b1),
        .sum   (diff),
        .FlagC (no_borrow)
    );

    // Final sign correction applied as results are loaded on entry to DONE
    always_comb begin
        q_fin = neg_q ? -q_reg : q_reg;
        r_fin = neg_r ? -rem_p[N-1:0] : rem_p[N-1:0];
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            rem_p     <= '0;
            q_reg     <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf       <= 1'b0;
            bus.Quot  <= '0;
            bus.Rem   <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.FlagZ <= 1'b0;
            bus.FlagV <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bus.B == '0) begin
                            state     <= DONE;
                            bus.done  <= 1'b1;
                            bus.Quot  <= '1;
                            bus.Rem   <= bus.A;
                            bus.FlagZ <= 1'b1;
                            bus.FlagV <= 1'b0;
                        end else begin
                            state <= CALC;
                            a_reg <= a_mag;
                            b_reg <= b_mag;
                            rem_p <= '0;
                            q_reg <= '0;
                            cnt   <= '0;
                            neg_q <= neg_q_in;
                            neg_r <= neg_r_in;
                            ovf   <= ovf_in;
                        end
                    end
                end
                CALC: begin
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        bus.done  <= 1'b1;
                        bus.Quot  <= q_fin;
                        bus.Rem   <= r_fin;
                        bus.FlagZ <= 1'b0;
                        bus.FlagV <= ovf;
                    end else begin
                        rem_p <= no_borrow ? diff : shifted;
                        q_reg <= {q_reg[N-2:0], no_borrow};
                        a_reg <= a_reg << 1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
